multicycle_ctrl_fsm: RTL

Main control FSM for the multicycle RV32 core, replacing the fixed-timing FSM.
- Adds a variable-latency memory handshake (mem_req/mem_ready) with a bus timeout.
- Adds a multi-cycle mul/div (M-extension) path with a start/done handshake.
- Adds an illegal-opcode trap, a single-step mode and an optional retired-instruction counter.
- Sits between the instruction register decode fields and the datapath mux/enable controls.

---
 rtl/multicycle_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multicycle RV32 core.
// Drives the datapath mux selects and enables from the IR decode fields,
// waits on a variable-latency memory and a multi-cycle mul/div unit, and
// traps on illegal opcodes or on a memory that never answers.
//
// Handshakes (valid/ready style):
//   mem_req is held high for every cycle of FETCH, MEMREAD and MEMWRITE; a
//   transfer completes in the cycle mem_req=1 and mem_ready=1, and the FSM
//   moves on at the following edge. md_start is a one-cycle command; md_done
//   marks the single cycle in which the mul/div result is valid.
//
// Debug encoding of state_o: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC_R, 4 EXEC_I,
// 5 EXEC_RC, 6 EXEC_IC, 7 AUIPC, 8 JAL, 9 LUI, 10 MEMADR, 11 MEMREAD,
// 12 MEMWRITE, 13 MEMWB, 14 ALUWB, 15 BRANCH, 16 MD_START, 17 MD_WAIT, 18 TRAP.
//
// Optional feature macro RETIRE_CNT_EN: when defined, `retired` counts retired
// instructions (wrapping); when undefined, `retired` is tied to 0.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_mode,
  input  logic [6:0]       op,
  input  logic             funct7_0,
  input  logic             mem_ready,
  input  logic             md_done,
  output logic             pc_update,
  output logic             branch,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             adr_src,
  output logic             sel_size,
  output logic             md_start,
  output logic             md_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             done,
  output logic [1:0]       trap_cause,
  output logic [4:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [4:0] {
    S_IDLE     = 5'd0,  S_FETCH    = 5'd1,  S_DECODE   = 5'd2,
    S_EXEC_R   = 5'd3,  S_EXEC_I   = 5'd4,  S_EXEC_RC  = 5'd5,
    S_EXEC_IC  = 5'd6,  S_AUIPC    = 5'd7,  S_JAL      = 5'd8,
    S_LUI      = 5'd9,  S_MEMADR   = 5'd10, S_MEMREAD  = 5'd11,
    S_MEMWRITE = 5'd12, S_MEMWB    = 5'd13, S_ALUWB    = 5'd14,
    S_BRANCH   = 5'd15, S_MD_START = 5'd16, S_MD_WAIT  = 5'd17,
    S_TRAP     = 5'd18
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_RC     = 7'b0110001;
  localparam logic [6:0] OP_IC     = 7'b0010001;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  // Wait counter only has to reach MEM_TIMEOUT-1; with the timeout disabled
  // it is free to wrap because nothing looks at it.
  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t              state, state_n;
  logic                retire;
  logic [1:0]          trap_set;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                mem_wait;
  logic                timeout;

  assign mem_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // A ready in the timeout cycle still wins: timeout requires mem_ready=0.
  assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && !mem_ready &&
                    (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1));
  assign state_o  = state;

  // State register, sticky trap cause and per-access wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      trap_cause <= 2'b00;
      wait_cnt   <= '0;
    end else begin
      state <= state_n;
      if (trap_set != 2'b00) trap_cause <= trap_set;
      // Staying in a memory wait state means the access did not complete;
      // any other transition (including entry) restarts the count.
      if (mem_wait && (state_n == state)) wait_cnt <= wait_cnt + 1'b1;
      else                                wait_cnt <= '0;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;

  // Retired-instruction counter, wrapping at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;
  end
  assign retired = retired_q;
`else
  assign retired = '0;
`endif

  // Next-state selection, retire detection and trap cause capture.
  always_comb begin
    state_n  = state;
    retire   = 1'b0;
    trap_set = 2'b00;
    case (state)
      S_IDLE:   if (run) state_n = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_n = S_DECODE;
        else if (timeout) begin state_n = S_TRAP; trap_set = CAUSE_BUS; end
      end
      S_DECODE: begin
        case (op)
          OP_R:                      state_n = funct7_0 ? S_MD_START : S_EXEC_R;
          OP_I:                      state_n = S_EXEC_I;
          OP_LOAD, OP_STORE, OP_JALR: state_n = S_MEMADR;
          OP_JAL:                    state_n = S_JAL;
          OP_LUI:                    state_n = S_LUI;
          OP_AUIPC:                  state_n = S_AUIPC;
          OP_RC:                     state_n = S_EXEC_RC;
          OP_IC:                     state_n = S_EXEC_IC;
          OP_BRANCH:                 state_n = S_BRANCH;
          default: begin state_n = S_TRAP; trap_set = CAUSE_ILLEGAL; end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_RC, S_EXEC_IC, S_AUIPC, S_JAL: state_n = S_ALUWB;
      S_MEMADR: begin
        case (op)
          OP_LOAD:  state_n = S_MEMREAD;
          OP_STORE: state_n = S_MEMWRITE;
          OP_JALR:  state_n = S_JAL;
          default: begin state_n = S_TRAP; trap_set = CAUSE_ILLEGAL; end
        endcase
      end
      S_MEMREAD: begin
        if (mem_ready)    state_n = S_MEMWB;
        else if (timeout) begin state_n = S_TRAP; trap_set = CAUSE_BUS; end
      end
      S_MEMWRITE: begin
        if (mem_ready)    retire = 1'b1;
        else if (timeout) begin state_n = S_TRAP; trap_set = CAUSE_BUS; end
      end
      S_MEMWB, S_ALUWB, S_LUI, S_BRANCH: retire = 1'b1;
      S_MD_START: state_n = S_MD_WAIT;
      S_MD_WAIT:  if (md_done) retire = 1'b1;
      S_TRAP:     state_n = S_TRAP;
      default:    state_n = S_IDLE;
    endcase
    if (retire) state_n = step_mode ? S_IDLE : S_FETCH;
  end

  // Datapath controls: Moore per state, except the fetch-time IR/PC writes
  // and the mul/div write-back, which follow their completion inputs.
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    sel_size   = 1'b0;
    md_start   = 1'b0;
    md_sel     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    done       = 1'b0;
    case (state)
      S_IDLE, S_TRAP: done = 1'b1;
      S_FETCH: begin
        mem_req    = 1'b1;
        sel_size   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_EXEC_R:   begin alu_src_a = 2'b10; alu_op = 2'b10; end
      S_EXEC_I:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
      S_EXEC_RC:  begin alu_src_a = 2'b10; alu_op = 2'b11; end
      S_EXEC_IC:  begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b11; end
      S_AUIPC:    begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update = 1'b1; end
      S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMREAD:  begin mem_req = 1'b1; adr_src = 1'b1; sel_size = 1'b1; end
      S_MEMWRITE: begin mem_req = 1'b1; mem_write = 1'b1; adr_src = 1'b1; sel_size = 1'b1; end
      S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
      S_ALUWB:    reg_write = 1'b1;
      S_LUI:      begin result_src = 2'b11; reg_write = 1'b1; end
      S_BRANCH:   begin alu_src_a = 2'b10; alu_op = 2'b01; branch = 1'b1; end
      S_MD_START: md_start = 1'b1;
      S_MD_WAIT:  begin md_sel = 1'b1; reg_write = md_done; end
      default:    done = 1'b0;
    endcase
  end

endmodule
